vga_display_pipe: RTL and testbench

//   Character-mode pixel pipeline placed directly downstream of vgatimer. It takes
//   x/y/hsync/vsync/activevideo, reads the tile code from screen memory and the pixel

---
 rtl/vga_display_pipe.sv | 169 ++++++++++++++++
 tb/tb_vga_display_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_display_pipe.sv
// Character-mode pixel pipeline behind vgatimer: tile lookup, bitmap fetch,
// blinking block cursor, realigned syncs and a per-frame tick.
module vga_display_pipe #(
    parameter int XBITS        = 10,
    parameter int YBITS        = 10,
    parameter int CODEBITS     = 4,
    parameter int COLS         = 40,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [XBITS-1:0]      x,
    input  logic [YBITS-1:0]      y,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  activevideo_in,
    output logic [10:0]           smem_addr,
    input  logic [CODEBITS-1:0]   smem_data,
    output logic [CODEBITS+7:0]   bmem_addr,
    input  logic [11:0]           bmem_data,
    input  logic                  cursor_en,
    input  logic [5:0]            cursor_col,
    input  logic [4:0]            cursor_row,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_tick
);

    localparam int CNTW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(BLINK_FRAMES - 1);
    localparam logic [5:0] COLS_W = 6'(COLS);
    localparam logic [4:0] ROWS_W = 5'(ROWS);

    logic [5:0]  w_col;
    logic [4:0]  w_row;
    logic [3:0]  w_xoff;
    logic [3:0]  w_yoff;
    logic [10:0] w_row_ext;
    logic [10:0] w_tile_addr;
    logic        w_hit;
    logic        w_fall;
    logic        w_unused_ybits;

    logic [3:0]  r_s1_xoff;
    logic [3:0]  r_s1_yoff;
    logic        r_s1_hs;
    logic        r_s1_vs;
    logic        r_s1_act;
    logic        r_s1_hit;

    logic        r_s2_hs;
    logic        r_s2_vs;
    logic        r_s2_act;
    logic        r_s2_hit;

    logic [11:0] r_rgb;
    logic        r_hs;
    logic        r_vs;

    logic            r_vs_prev;
    logic            r_frame_tick;
    logic [CNTW-1:0] r_blink_cnt;
    logic            r_blink_phase;

    assign w_col  = x[9:4];
    assign w_row  = y[8:4];
    assign w_xoff = x[3:0];
    assign w_yoff = y[3:0];
    assign w_unused_ybits = ^y[YBITS-1:9];

    // row*40 built from two shifts; col is added on top
    assign w_row_ext   = {6'b0, w_row};
    assign w_tile_addr = (w_row_ext << 5) + (w_row_ext << 3) + {5'b0, w_col};
    assign smem_addr   = activevideo_in ? w_tile_addr : 11'd0;

    // out-of-range cursor positions never match any tile
    assign w_hit = cursor_en
                 && (cursor_col < COLS_W) && (cursor_row < ROWS_W)
                 && (w_col == cursor_col) && (w_row == cursor_row);

    assign bmem_addr = {smem_data, r_s1_yoff, r_s1_xoff};

    assign w_fall = r_vs_prev & ~vsync_in;

    // stage 1: hold pixel offsets and control while screen memory reads
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s1_xoff <= 4'd0;
            r_s1_yoff <= 4'd0;
            r_s1_hs   <= 1'b1;
            r_s1_vs   <= 1'b1;
            r_s1_act  <= 1'b0;
            r_s1_hit  <= 1'b0;
        end else begin
            r_s1_xoff <= w_xoff;
            r_s1_yoff <= w_yoff;
            r_s1_hs   <= hsync_in;
            r_s1_vs   <= vsync_in;
            r_s1_act  <= activevideo_in;
            r_s1_hit  <= w_hit;
        end
    end

    // stage 2: carry control while bitmap memory reads
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_s2_hs  <= 1'b1;
            r_s2_vs  <= 1'b1;
            r_s2_act <= 1'b0;
            r_s2_hit <= 1'b0;
        end else begin
            r_s2_hs  <= r_s1_hs;
            r_s2_vs  <= r_s1_vs;
            r_s2_act <= r_s1_act;
            r_s2_hit <= r_s1_hit;
        end
    end

    // stage 3: blank, apply inverted cursor, register pins
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rgb <= 12'd0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
        end else begin
            if (!r_s2_act)
                r_rgb <= 12'd0;
            else if (r_s2_hit && r_blink_phase)
                r_rgb <= ~bmem_data;
            else
                r_rgb <= bmem_data;
            r_hs <= r_s2_hs;
            r_vs <= r_s2_vs;
        end
    end

    // frame tick on vsync falling edge and cursor blink timebase
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_vs_prev     <= 1'b1;
            r_frame_tick  <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_vs_prev    <= vsync_in;
            r_frame_tick <= w_fall;
            if (w_fall) begin
                if (r_blink_cnt == CNT_MAX) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    assign red        = r_rgb[11:8];
    assign green      = r_rgb[7:4];
    assign blue       = r_rgb[3:0];
    assign hsync      = r_hs;
    assign vsync      = r_vs;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_display_pipe.sv
// Bench for vga_display_pipe: memory models, directed cases and a random
// run checked against a per-pixel reference model.
module tb_vga_display_pipe;

    logic        clk;
    logic        resetn;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hsync_in;
    logic        vsync_in;
    logic        activevideo_in;
    logic [10:0] smem_addr;
    logic [3:0]  smem_data;
    logic [11:0] bmem_addr;
    logic [11:0] bmem_data;
    logic        cursor_en;
    logic [5:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hsync;
    logic        vsync;
    logic        frame_tick;

    vga_display_pipe dut (
        .clk            (clk),
        .resetn         (resetn),
        .x              (x),
        .y              (y),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .activevideo_in (activevideo_in),
        .smem_addr      (smem_addr),
        .smem_data      (smem_data),
        .bmem_addr      (bmem_addr),
        .bmem_data      (bmem_data),
        .cursor_en      (cursor_en),
        .cursor_col     (cursor_col),
        .cursor_row     (cursor_row),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .hsync          (hsync),
        .vsync          (vsync),
        .frame_tick     (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  smem [2048];
    logic [11:0] bmem [4096];

    // synchronous-read memory models
    always @(posedge clk) begin
        smem_data <= smem[smem_addr];
        bmem_data <= bmem[bmem_addr];
    end

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        act;
        logic        hit;
        logic [11:0] pix;
    } rec_t;

    localparam rec_t IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, hit: 1'b0, pix: 12'd0};

    int   n_checks;
    int   n_errors;
    rec_t h0, h1, h2;
    int   m_cnt;
    bit   m_phase;
    bit   m_vsprev;
    int   ticks_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: model the pixel presented now, compare pins after the edge
    task automatic cycle();
        int   a, code, xi, yi, baddr;
        rec_t r;
        bit   fall, ph;
        logic [11:0] exp_rgb;
        @(negedge clk);
        xi = int'(x);
        yi = int'(y);
        a = activevideo_in ? ((yi / 16) % 32) * 40 + (xi / 16) % 64 : 0;
        chk("smem_addr", 32'(smem_addr), 32'(a));
        code  = int'(smem[a]);
        baddr = code * 256 + (yi % 16) * 16 + (xi % 16);
        r.hs  = hsync_in;
        r.vs  = vsync_in;
        r.act = activevideo_in;
        r.pix = bmem[baddr];
        r.hit = cursor_en && int'(cursor_col) < 40 && int'(cursor_row) < 30
              && (xi / 16) % 64 == int'(cursor_col)
              && (yi / 16) % 32 == int'(cursor_row);
        fall = m_vsprev && !vsync_in;
        @(posedge clk);
        #1;
        if (!resetn) begin
            h0 = IDLE;
            h1 = IDLE;
            h2 = IDLE;
            m_cnt = 0;
            m_phase = 1'b0;
            m_vsprev = 1'b1;
            fall = 1'b0;
            ph = 1'b0;
        end else begin
            ph = m_phase;
            h2 = h1;
            h1 = h0;
            h0 = r;
            if (fall) begin
                if (m_cnt == 29) begin
                    m_cnt = 0;
                    m_phase = !m_phase;
                end else begin
                    m_cnt++;
                end
            end
            m_vsprev = vsync_in;
            chk("bmem_addr", 32'(bmem_addr), 32'(baddr));
        end
        exp_rgb = !h2.act ? 12'd0 : (h2.hit && ph) ? ~h2.pix : h2.pix;
        chk("rgb", 32'({red, green, blue}), 32'(exp_rgb));
        chk("hsync", 32'(hsync), 32'(h2.hs));
        chk("vsync", 32'(vsync), 32'(h2.vs));
        chk("frame_tick", 32'(frame_tick), 32'(fall));
        if (frame_tick) ticks_seen++;
    endtask

    initial begin
        int lowcnt, first_low;
        n_checks = 0;
        n_errors = 0;
        ticks_seen = 0;
        h0 = IDLE;
        h1 = IDLE;
        h2 = IDLE;
        m_cnt = 0;
        m_phase = 1'b0;
        m_vsprev = 1'b1;
        for (int i = 0; i < 2048; i++) smem[i] = 4'($urandom);
        for (int i = 0; i < 4096; i++) bmem[i] = 12'($urandom);

        // reset with arbitrary inputs
        resetn = 1'b0;
        x = 10'($urandom);
        y = 10'($urandom);
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        activevideo_in = 1'b1;
        cursor_en = 1'b1;
        cursor_col = 6'd3;
        cursor_row = 5'd4;
        cycle();
        cycle();
        chk("reset_rgb", 32'({red, green, blue}), 32'd0);
        chk("reset_hsync", 32'(hsync), 32'd1);
        chk("reset_vsync", 32'(vsync), 32'd1);
        chk("reset_tick", 32'(frame_tick), 32'd0);

        // basic lookup at tile (1,2)
        resetn = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        cursor_en = 1'b0;
        smem[81] = 4'd5;
        bmem[12'h500] = 12'hABC;
        x = 10'd16;
        y = 10'd32;
        activevideo_in = 1'b1;
        cycle();
        chk("lookup_bmem_addr", 32'(bmem_addr), 32'h500);
        cycle();
        cycle();
        chk("lookup_rgb", 32'({red, green, blue}), 32'hABC);
        cycle();

        // blanking forces black and address 0
        bmem[{smem[0], 8'h00}] = 12'hFFF;
        activevideo_in = 1'b0;
        cycle();
        chk("blank_addr", 32'(smem_addr), 32'd0);
        cycle();
        cycle();
        chk("blank_rgb", 32'({red, green, blue}), 32'd0);
        cycle();

        // long hsync pulse keeps its length and gains 3 clk of latency
        activevideo_in = 1'b1;
        lowcnt = 0;
        first_low = -1;
        for (int i = 0; i < 392; i++) begin
            hsync_in = (i < 384) ? 1'b0 : 1'b1;
            x = 10'(i / 4);
            cycle();
            if (!hsync) begin
                lowcnt++;
                if (first_low < 0) first_low = i;
            end
        end
        chk("hs_low_len", 32'(lowcnt), 32'd384);
        chk("hs_start_edge", 32'(first_low), 32'd2);

        // cursor blink after 30 frames
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        activevideo_in = 1'b0;
        x = 10'd0;
        y = 10'd0;
        cursor_en = 1'b1;
        cursor_col = 6'd1;
        cursor_row = 5'd2;
        ticks_seen = 0;
        for (int i = 0; i < 30; i++) begin
            vsync_in = 1'b0;
            cycle();
            vsync_in = 1'b1;
            cycle();
        end
        chk("tick_count", 32'(ticks_seen), 32'd30);
        bmem[{4'd5, 4'd3, 4'd7}] = 12'h0F0;
        smem[82] = 4'd6;
        bmem[{4'd6, 4'd3, 4'd7}] = 12'h0F0;
        activevideo_in = 1'b1;
        x = 10'd23;
        y = 10'd35;
        cycle();
        cycle();
        cycle();
        chk("cursor_rgb", 32'({red, green, blue}), 32'hF0F);
        cycle();
        x = 10'd39;
        cycle();
        cycle();
        cycle();
        chk("neighbour_rgb", 32'({red, green, blue}), 32'h0F0);
        cycle();

        // randomized run with a mid-line reset
        for (int i = 0; i < 2500; i++) begin
            resetn = !(i >= 1200 && i < 1203);
            if ($urandom_range(0, 5) == 0) vsync_in = ~vsync_in;
            if ($urandom_range(0, 7) == 0) hsync_in = ~hsync_in;
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    x = 10'(int'(cursor_col) * 16 + $urandom_range(0, 15));
                    y = 10'(int'(cursor_row) * 16 + $urandom_range(0, 15));
                end else begin
                    x = 10'($urandom_range(0, 1023));
                    y = 10'($urandom_range(0, 1023));
                end
            end
            activevideo_in = (x < 10'd640 && y < 10'd480) ^ ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) begin
                cursor_en = 1'($urandom);
                cursor_col = 6'($urandom_range(0, 45));
                cursor_row = 5'($urandom_range(0, 31));
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
